// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: opcodes, the NOP word, the fetch FSM states and a jump predecode helper.
// Latency: none (types and constants only).
// Backpressure: none.
package mips_pkg;

  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // True for the absolute jumps whose target is computable from the word alone.
  function automatic logic is_jump(input logic [31:0] word);
    return (word[31:26] == OP_J) || (word[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// Latency: ImemRdata is valid in the same cycle as ImemAck.
// Backpressure: the requester holds ImemReq and ImemAddr until ImemAck.
interface fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;

  modport master (output ImemReq, ImemAddr, input ImemAck, ImemRdata);
  modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemRdata);
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC select: redirect target, else early jump target (FETCH_JUMP_EARLY_EN), else PC+4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the PC register loads.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_word,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_seq_pc;
  logic        w_unused_bits;

  // PC+4 wraps naturally at 2^32.
  assign w_pc_plus4 = i_pc + 32'd4;

`ifdef FETCH_JUMP_EARLY_EN
  // J/JAL targets are taken straight from the returned word, in the PC+4 region.
  assign w_seq_pc      = is_jump(i_word) ? {w_pc_plus4[31:28], i_word[25:0], 2'b00} : w_pc_plus4;
  assign w_unused_bits = ^i_redirect_pc[1:0];
`else
  assign w_seq_pc      = w_pc_plus4;
  assign w_unused_bits = ^{i_word, i_redirect_pc[1:0]};
`endif

  // A downstream redirect always wins; misaligned targets are forced to a word boundary.
  assign o_next_pc = i_redirect ? {i_redirect_pc[31:2], 2'b00} : w_seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per cycle into the IF/ID slot. Optional FETCH_JUMP_EARLY_EN.
// Latency: acked word visible on FetchData_IF one cycle after the ack edge.
// Backpressure: AnyStall holds the slot; an ack taken under stall parks in a 1-entry skid and stops requests.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         AnyStall,
  input  logic         flush,
  input  logic         Redirect_EX,
  input  logic [31:0]  RedirectPc_EX,
  fetch_unit_if.master imem,
  output logic [31:0]  FetchData_IF,
  output logic [31:0]  FetchPc_IF,
  output logic         FetchValid_IF
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_sq_addr;
  logic        r_squash;
  logic [31:0] r_skid_dat;
  logic [31:0] r_skid_pc;
  logic        r_skid_vld;
  logic [31:0] r_slot_dat;
  logic [31:0] r_slot_pc;
  logic        r_slot_vld;

  logic        w_imem_req;
  logic        w_ack;
  logic        w_take;
  logic        w_to_slot;
  logic        w_to_skid;
  logic        w_hold_exit;
  logic        w_skid_use;
  logic        w_pc_en;
  logic [31:0] w_next_pc;

  // An ack only counts while a request is on the bus.
  assign w_ack       = (r_state == REQ) && imem.ImemAck;
  // The word belongs to the current path only if no redirect intervened.
  assign w_take      = w_ack && !r_squash && !Redirect_EX;
  assign w_to_slot   = w_take && !AnyStall && !flush;
  assign w_to_skid   = w_take && (AnyStall || flush);
  // Leaving HOLD under flush would overwrite the freshly killed slot, so wait one more cycle.
  assign w_hold_exit = (r_state == HOLD) && !AnyStall && !flush;
  assign w_skid_use  = w_hold_exit && r_skid_vld && !Redirect_EX;
  assign w_pc_en     = Redirect_EX || w_take;

  fetch_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_word        (imem.ImemRdata),
    .i_redirect    (Redirect_EX),
    .i_redirect_pc (RedirectPc_EX),
    .o_next_pc     (w_next_pc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and request strobe
  always_comb begin
    w_state_nxt = r_state;
    w_imem_req  = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        w_imem_req = 1'b1;
        if (w_to_skid) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_hold_exit) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // While squashing, keep presenting the abandoned address until its ack drains.
  assign imem.ImemReq  = w_imem_req;
  assign imem.ImemAddr = r_squash ? r_sq_addr : r_pc;

  // Program counter: redirect, else advance on an accepted word
  always_ff @(posedge clk) begin
    if (reset)        r_pc <= RESET_PC;
    else if (w_pc_en) r_pc <= w_next_pc;
  end

  // Squash flag: a redirect while a request is outstanding discards that request's ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_squash  <= 1'b0;
      r_sq_addr <= '0;
    end else if (Redirect_EX && (r_state == REQ) && !imem.ImemAck) begin
      r_squash <= 1'b1;
      if (!r_squash) r_sq_addr <= r_pc;
    end else if (w_ack) begin
      r_squash <= 1'b0;
    end
  end

  // Skid entry: parks a word acked while the slot cannot take it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_vld <= 1'b0;
      r_skid_dat <= NOP_INSTR;
      r_skid_pc  <= '0;
    end else if (Redirect_EX) begin
      r_skid_vld <= 1'b0;
    end else if (w_to_skid) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= imem.ImemRdata;
      r_skid_pc  <= r_pc;
    end else if (w_hold_exit) begin
      r_skid_vld <= 1'b0;
    end
  end

  // IF/ID slot: flush kills, stall holds, otherwise load a word or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_dat <= NOP_INSTR;
      r_slot_pc  <= '0;
      r_slot_vld <= 1'b0;
    end else if (flush) begin
      r_slot_dat <= NOP_INSTR;
      r_slot_vld <= 1'b0;
    end else if (!AnyStall) begin
      if (w_to_slot) begin
        r_slot_dat <= imem.ImemRdata;
        r_slot_pc  <= r_pc;
        r_slot_vld <= 1'b1;
      end else if (w_skid_use) begin
        r_slot_dat <= r_skid_dat;
        r_slot_pc  <= r_skid_pc;
        r_slot_vld <= 1'b1;
      end else begin
        r_slot_dat <= NOP_INSTR;
        r_slot_vld <= 1'b0;
      end
    end
  end

  assign FetchData_IF  = r_slot_dat;
  assign FetchPc_IF    = r_slot_pc;
  assign FetchValid_IF = r_slot_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random stall/flush/redirect/ack traffic.
// Latency: expected words are queued at acceptance and checked when they appear in the IF/ID slot.
// Backpressure: the bench plays instruction memory and drives ImemAck randomly.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef FETCH_JUMP_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [31:0] EXP_J = EARLY ? 32'h0000_0100 : 32'h0000_0014;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        AnyStall = 1'b0;
  logic        flush = 1'b0;
  logic        Redirect_EX = 1'b0;
  logic [31:0] RedirectPc_EX = '0;
  logic [31:0] FetchData_IF;
  logic [31:0] FetchPc_IF;
  logic        FetchValid_IF;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .AnyStall      (AnyStall),
    .flush         (flush),
    .Redirect_EX   (Redirect_EX),
    .RedirectPc_EX (RedirectPc_EX),
    .imem          (imem),
    .FetchData_IF  (FetchData_IF),
    .FetchPc_IF    (FetchPc_IF),
    .FetchValid_IF (FetchValid_IF)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  exp_t        q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          stale = 1'b0;
  bit          e_rst = 1'b1;
  bit          e_stall = 1'b0;
  bit          e_flush = 1'b0;
  bit          p_rst = 1'b0;
  bit          p_wait = 1'b0;
  bit          p_acc_stall = 1'b0;
  bit          p_new_req = 1'b0;
  logic [31:0] p_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed function of the address so stale and fresh words differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h2001_0001 + (a >> 2);
    if (a == 32'h0000_0010)      w = 32'h0800_0040;
    else if (a[6:2] == 5'd21)    w = {6'b000011, a[27:2] ^ 26'h2AA_AAAA};
    return w;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] p4;
    bit          jmp;
    p4  = pc + 32'd4;
    jmp = (w[31:26] == 6'd2) || (w[31:26] == 6'd3);
    if (EARLY && jmp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    return p4;
  endfunction

  // Drive one cycle of stimulus (called at a negedge), update the model, then check the request bus.
  task automatic step(input bit rst, input bit stall, input bit fl, input bit red,
                      input logic [31:0] rpc, input bit ack);
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdat;
    bit          acc;
    exp_t        e;
    req  = imem.ImemReq;
    addr = imem.ImemAddr;
    rdat = mem_word(addr);
    reset = rst; AnyStall = stall; flush = fl; Redirect_EX = red; RedirectPc_EX = rpc;
    imem.ImemAck = ack; imem.ImemRdata = rdat;
    e_rst = rst; e_stall = stall; e_flush = fl;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      m_pc  = RESET_PC;
      stale = 1'b0;
    end else begin
      if (red) q.delete();
      acc = req && ack && !stale && !red;
      if (acc) begin
        chk("fetch_addr", addr, m_pc);
        e.pc = m_pc; e.dat = rdat;
        q.push_back(e);
        n_acc++;
      end
      if (req && ack)      stale = 1'b0;
      else if (req && red) stale = 1'b1;
      if (red)      m_pc = rpc & 32'hFFFF_FFFC;
      else if (acc) m_pc = model_next(m_pc, rdat);
    end
    p_rst       = rst;
    p_wait      = !rst && req && !ack;
    p_addr      = addr;
    p_acc_stall = acc && (stall || fl);
    p_new_req   = !rst && req && ack && !(acc && (stall || fl));
    @(negedge clk);
    if (p_rst)       chk("req_after_reset", {31'b0, imem.ImemReq}, 32'd0);
    if (p_wait) begin
      chk("req_held", {31'b0, imem.ImemReq}, 32'd1);
      chk("addr_held", imem.ImemAddr, p_addr);
    end
    if (p_acc_stall) chk("req_in_hold", {31'b0, imem.ImemReq}, 32'd0);
    if (p_new_req) begin
      chk("next_req", {31'b0, imem.ImemReq}, 32'd1);
      chk("next_addr", imem.ImemAddr, m_pc);
    end
  endtask

  // Monitor: checks the IF/ID slot just after every edge against the expected-word queue.
  initial begin : monitor
    exp_t        e;
    logic [31:0] last_dat = NOP;
    logic        last_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (e_rst) begin
        chk("rst_valid", {31'b0, FetchValid_IF}, 32'd0);
        chk("rst_data", FetchData_IF, NOP);
        chk("rst_pc", FetchPc_IF, 32'd0);
      end else if (e_flush) begin
        chk("flush_valid", {31'b0, FetchValid_IF}, 32'd0);
        chk("flush_data", FetchData_IF, NOP);
      end else if (e_stall) begin
        chk("stall_hold_data", FetchData_IF, last_dat);
        chk("stall_hold_valid", {31'b0, FetchValid_IF}, {31'b0, last_vld});
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("slot_valid", {31'b0, FetchValid_IF}, 32'd1);
        chk("slot_pc", FetchPc_IF, e.pc);
        chk("slot_data", FetchData_IF, e.dat);
      end else begin
        chk("bubble_valid", {31'b0, FetchValid_IF}, 32'd0);
        chk("bubble_data", FetchData_IF, NOP);
      end
      last_dat = FetchData_IF;
      last_vld = FetchValid_IF;
    end
  end

  initial begin : stimulus
    logic [31:0] rpc;
    imem.ImemAck   = 1'b0;
    imem.ImemRdata = '0;
    @(negedge clk);
    // Reset, then streaming fetch with ack tied high
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Stall for three cycles across the ack at PC 0x8
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("hold_no_req", {31'b0, imem.ImemReq}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("release_addr", imem.ImemAddr, 32'h0000_000C);
    // Jump word at 0x10
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("jump_next_addr", imem.ImemAddr, EXP_J);
    // Delayed ack with a redirect in the second wait cycle
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0100, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("redirect_addr", imem.ImemAddr, 32'h0000_0100);
    // Load one word, then flush under stall
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("flush_stall_valid", {31'b0, FetchValid_IF}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    // Misaligned redirect to the top word, then wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("top_addr", imem.ImemAddr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_addr", imem.ImemAddr, 32'h0000_0000);
    // Reset while a request is pending, with an ack in the reset cycle
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFF);
      else                           rpc = $urandom & 32'h0000_0FFF;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 6,
           rpc,
           $urandom_range(0, 99) < 60);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("progress", {31'b0, n_acc > 300}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
